// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports and per-register in-flight write counters.
// Optional write-through bypass onto the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 3,
  parameter int ZERO_REG     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        reg_we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] to_reg,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_full
);

  localparam bit         ZR      = (ZERO_REG != 0);
  localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

  logic [31:0] regs_q [NUM_REGS];
  logic [1:0]  cnt_q  [NUM_REGS];
  logic [1:0]  cnt_d  [NUM_REGS];
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;

  logic wr_en;
  logic issue_zero;
  logic inc;
  logic dec;

  assign wr_en      = reg_we && !(ZR && rd_addr == 5'd0);
  assign issue_zero = ZR && issue_rd == 5'd0;

  assign rs1_busy   = cnt_q[rs1_addr] != 2'd0;
  assign rs2_busy   = cnt_q[rs2_addr] != 2'd0;
  assign issue_full = (cnt_q[issue_rd] == MAX_CNT) && !issue_zero;

  assign inc = issue_valid && !issue_full && !issue_zero;
  assign dec = reg_we && cnt_q[rd_addr] != 2'd0;

  // Matching inc/dec on one register cancel; otherwise both apply independently.
  always_comb begin
    cnt_d = cnt_q;
    if (!(inc && dec && issue_rd == rd_addr)) begin
      if (inc) cnt_d[issue_rd] = cnt_q[issue_rd] + 2'd1;
      if (dec) cnt_d[rd_addr]  = cnt_q[rd_addr] - 2'd1;
    end
  end

  always_comb begin
    rs1_d = (ZR && rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
    rs2_d = (ZR && rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && rd_addr == rs1_addr) rs1_d = to_reg;
    if (wr_en && rd_addr == rs2_addr) rs2_d = to_reg;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      cnt_q  <= '{default: '0};
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (clk_en) begin
      if (wr_en) regs_q[rd_addr] <= to_reg;
      cnt_q <= cnt_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard; read-data expectations flow through a queue.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clk_en, reg_we, issue_valid;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr, issue_rd;
  logic [31:0] to_reg, rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, issue_full;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .reg_we(reg_we), .rd_addr(rd_addr),
    .to_reg(to_reg), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_full(issue_full)
  );

  typedef struct {
    bit          rst, en, we;
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          iv;
    logic [4:0]  ird, a1, a2;
    bit          b1, b2, full;
    logic [31:0] d1, d2;
  } vec_t;

  typedef struct {
    logic [31:0] d1, d2;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(bit r, bit en, bit we, logic [4:0] rd, logic [31:0] wd,
                              bit iv, logic [4:0] ird, logic [4:0] a1, logic [4:0] a2,
                              bit b1, bit b2, bit full, logic [31:0] d1, logic [31:0] d2);
    vec_t v;
    v.rst = r; v.en = en; v.we = we; v.rd = rd; v.wd = wd; v.iv = iv; v.ird = ird;
    v.a1 = a1; v.a2 = a2; v.b1 = b1; v.b2 = b2; v.full = full; v.d1 = d1; v.d2 = d2;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int i);
    exp_t e;
    rst = v.rst; clk_en = v.en; reg_we = v.we; rd_addr = v.rd; to_reg = v.wd;
    issue_valid = v.iv; issue_rd = v.ird; rs1_addr = v.a1; rs2_addr = v.a2;
    #1;
    chk($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(v.b1));
    chk($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(v.b2));
    chk($sformatf("v%0d issue_full", i), 32'(issue_full), 32'(v.full));
    e.d1 = v.d1; e.d2 = v.d2; e.idx = i;
    expq.push_back(e);
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL v%0d queue: got empty expected entry", i);
    end else begin
      e = expq.pop_front();
      chk($sformatf("v%0d rs1_data", e.idx), rs1_data, e.d1);
      chk($sformatf("v%0d rs2_data", e.idx), rs2_data, e.d2);
    end
  endtask

  initial begin
    // Reset then read
    rst = 1'b1; clk_en = 1'b1; reg_we = 1'b0; rd_addr = '0; to_reg = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_addr = 5'd5; rs2_addr = 5'd31;
    @(posedge clk);
    #1;
    chk("reset rs1_data", rs1_data, 32'h0);
    chk("reset rs2_data", rs2_data, 32'h0);
    chk("reset rs1_busy", 32'(rs1_busy), 32'h0);
    chk("reset rs2_busy", 32'(rs2_busy), 32'h0);

    //               rst en we rd  wd             iv ird a1 a2  b1 b2 fu d1                     d2
    // write then read
    vecs.push_back(mk(0, 1, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0,  0, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 7, 0,  0, 0, 0, 32'hDEADBEEF, 32'h0));
    // collision on r7
    vecs.push_back(mk(0, 1, 1, 7, 32'h1111,     0, 0, 0, 0,  0, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 1, 7, 32'h2222,     0, 0, 0, 7,  0, 0, 0, 32'h0,  BYP ? 32'h2222 : 32'h1111));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 7,  0, 0, 0, 32'h0,  32'h2222));
    // zero register
    vecs.push_back(mk(0, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,  0, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 0, 0,  0, 0, 0, 32'h0,  32'h0));
    // saturation on r3: three issues, an ignored fourth
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 3, 3, 0,  0, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 3, 3, 0,  1, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 3, 3, 0,  1, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 3, 3, 0,  1, 0, 1, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 3, 3, 0,  1, 0, 1, 32'h0,  32'h0));
    // four writebacks to r3
    vecs.push_back(mk(0, 1, 1, 3, 32'h3000000A, 0, 3, 3, 0,  1, 0, 1, BYP ? 32'h3000000A : 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 3, 32'h3000000B, 0, 3, 3, 0,  1, 0, 0, BYP ? 32'h3000000B : 32'h3000000A, 32'h0));
    vecs.push_back(mk(0, 1, 1, 3, 32'h3000000C, 0, 3, 3, 0,  1, 0, 0, BYP ? 32'h3000000C : 32'h3000000B, 32'h0));
    vecs.push_back(mk(0, 1, 1, 3, 32'h3000000D, 0, 3, 3, 0,  0, 0, 0, BYP ? 32'h3000000D : 32'h3000000C, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 3, 3, 0,  0, 0, 0, 32'h3000000D, 32'h0));
    // simultaneous issue/writeback on r4
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 4, 4, 0,  0, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 1, 4, 32'h44,       1, 4, 4, 0,  1, 0, 0, BYP ? 32'h44 : 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 4, 4, 4,  1, 1, 0, 32'h44, 32'h44));
    // clk_en low: nothing moves
    vecs.push_back(mk(0, 0, 1, 4, 32'h55,       1, 4, 7, 3,  0, 0, 0, 32'h44, 32'h44));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 4, 4, 4,  1, 1, 0, 32'h44, 32'h44));
    vecs.push_back(mk(0, 1, 1, 4, 32'h66,       0, 4, 4, 0,  1, 0, 0, BYP ? 32'h66 : 32'h44, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 4, 4, 0,  0, 0, 0, 32'h66, 32'h0));
    // mid-operation reset with clk_en low, then a late writeback
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 9, 9, 0,  0, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 9, 9, 7,  1, 0, 0, 32'h0,  32'h2222));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 9, 9, 31, 1, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk(0, 1, 1, 9, 32'h99,       0, 9, 9, 7,  0, 0, 0, BYP ? 32'h99 : 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 9, 9, 0,  0, 0, 0, 32'h99, 32'h0));

    foreach (vecs[i]) apply(vecs[i], i);

    if (expq.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL leftover queue: got %0d entries expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- General-purpose register file and per-register write scoreboard for the S1 core.
- It is the receiving end of the writeback interface: it consumes reg_we / rd_addr / to_reg from the writeback stage.
- It serves two registered read ports to the decode stage.
- It tracks in-flight destination writes, so decode can stall on read-after-write hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; address width is fixed at 5.
- MAX_INFLIGHT, 3, maximum outstanding writes per register; scoreboard counter width is 2 bits.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clk_en  input  1  pipeline advance enable; when low, no state changes except reset.
- reg_we  input  1  writeback write enable.
- rd_addr  input  5  writeback destination register.
- to_reg  input  32  writeback data.
- rs1_addr  input  5  read port 1 address.
- rs2_addr  input  5  read port 2 address.
- rs1_data  output  32  registered read data, port 1.
- rs2_data  output  32  registered read data, port 2.
- rs1_busy  output  1  combinational: scoreboard count of rs1_addr is nonzero.
- rs2_busy  output  1  combinational: scoreboard count of rs2_addr is nonzero.
- issue_valid  input  1  decode issues an instruction that will write issue_rd.
- issue_rd  input  5  destination of the issuing instruction.
- issue_full  output  1  combinational: count of issue_rd equals MAX_INFLIGHT.

Behaviour:
- Reset (rst=1 at a rising edge, priority over clk_en):
  - all registers cleared to 0;
  - all scoreboard counters cleared to 0;
  - rs1_data and rs2_data cleared to 0.
  - Reset mid-operation discards all pending counts; writebacks that arrive later still write data, and their counter decrement saturates at 0.
- clk_en=0: registers, counters and read outputs all hold; reg_we and issue_valid are ignored.
- Write: on a clk_en edge with reg_we=1, regs[rd_addr] <= to_reg. If ZERO_REG=1 and rd_addr=0, the write is dropped.
- Read:
  - On a clk_en edge, rsN_data <= regs[rsN_addr]. Read latency is 1 cycle.
  - If ZERO_REG=1 and rsN_addr=0, the result is 0.
  - Same-cycle write/read collision behaviour is defined under Optional Feature.
- Scoreboard, per-register 2-bit counter cnt[r], updated on clk_en edges only:
  - inc = issue_valid && !issue_full && !(ZERO_REG && issue_rd==0).
  - dec = reg_we && cnt[rd_addr]!=0.
  - If inc and dec target the same register in the same cycle, the count is unchanged.
  - Otherwise cnt[issue_rd]+1 and cnt[rd_addr]-1 are applied independently.
  - Decrement saturates at 0. A writeback to a register with count 0 is legal and writes data.
  - An issue while issue_full=1 is ignored. Decode must hold the instruction until issue_full drops.
- Busy flags:
  - rsN_busy = cnt[rsN_addr]!=0, evaluated on the current addresses with no registering.
  - The flags do not account for a same-cycle writeback; the count drops on the next edge.
- issue_full = cnt[issue_rd]==MAX_INFLIGHT. It is forced to 0 for register 0 when ZERO_REG=1.
- No combinational path from reg_we/to_reg to any output, except through the bypass on the registered read data.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: on a clk_en edge with reg_we=1 and rd_addr==rsN_addr (and not the zero register), rsN_data <= to_reg (new value, write-through).
- Undefined: rsN_data <= old regs[rsN_addr]. The new value becomes readable one cycle later.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset then read: rst=1 for 1 cycle, rs1_addr=5, rs2_addr=31 → one cycle later rs1_data=0, rs2_data=0, rs1_busy=0, rs2_busy=0.
- Write then read: reg_we=1, rd_addr=7, to_reg=0xDEADBEEF; next cycle rs1_addr=7 → rs1_data=0xDEADBEEF one cycle after the read address is presented.
- Collision:
  - Stimulus: r7=0x1111 beforehand; in one cycle, reg_we=1, rd_addr=7, to_reg=0x2222 and rs2_addr=7.
  - With REGFILE_BYPASS_EN: rs2_data=0x2222.
  - Without it: rs2_data=0x1111, and 0x2222 appears on the following read.
- Zero register: write rd_addr=0, to_reg=0xFFFFFFFF; issue_valid=1, issue_rd=0 → rs1_addr=0 reads 0; rs1_busy=0; issue_full=0.
- Scoreboard saturation:
  - Stimulus: issue r3 three times → rs1_busy=1 for rs1_addr=3 and issue_full=1; a 4th issue is ignored.
  - Then three writebacks to r3 → busy clears after the third; a 4th writeback writes data and cnt stays 0.
- Simultaneous events and clk_en hold:
  - Stimulus 1: r4 count=1; issue r4 and writeback r4 in the same cycle → count stays 1 and rs1_busy stays 1.
  - Stimulus 2: clk_en=0 with reg_we=1, issue_valid=1 → no data or count change.
